// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A fetch entry pairs an instruction word with the PC it was fetched from.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries. Flush empties the queue and overrides push/pop.
// The head entry is read straight from storage, so it is stable while not popped.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: storage is cleared on reset because the head word is visible on Instr/InstrPC.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and buffers
// {pc, instr} pairs for the datapath behind a valid/ready handshake.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int              DEPTH    = 4,
  parameter  logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstrPC,
  input  logic               InstrReady,
  output logic [CW-1:0]      Count
);

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            in_flight_q, in_flight_d;
  logic [CW:0]     credit;
  logic            fifo_push, fifo_pop;
  fetch_entry_t    push_entry, head;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    // Credit counts the in-flight word so a returning response always has a free slot.
    credit      = {1'b0, fifo_count} + (CW+1)'(in_flight_q);
    ImemReq     = !Reset && !Redirect && (credit < (CW+1)'(DEPTH));
    fpc_d       = fpc_q;
    pend_pc_d   = pend_pc_q;
    in_flight_d = 1'b0;
    if (Redirect) begin
      fpc_d = {RedirectPC[PC_W-1:2], 2'b00};
    end else if (ImemReq) begin
      fpc_d       = fpc_q + PC_INC;
      pend_pc_d   = fpc_q;
      in_flight_d = 1'b1;
    end
    fifo_push  = in_flight_q && !Redirect;
    fifo_pop   = (fifo_count != '0) && InstrReady && !Redirect;
    push_entry = '{pc: pend_pc_q, instr: ImemData};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fpc_q       <= RESET_PC;
      pend_pc_q   <= '0;
      in_flight_q <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      pend_pc_q   <= pend_pc_d;
      in_flight_q <= in_flight_d;
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (Redirect),
    .head      (head),
    .count     (fifo_count)
  );

  assign ImemAddr   = fpc_q;
  assign InstrValid = (fifo_count != '0);
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;
  assign Count      = fifo_count;

endmodule
